delay_counter_8b: RTL and testbench
===================================

Name: delay_counter_8b

Overview:
- 8-bit synchronous up-counter with parallel load and a start/stop enable.
- Used as a programmable delay/elapsed-cycle counter: software or an FSM presets a value, starts counting and reads the current count.
- Single clock domain; asynchronous active-low clear.
- Pin-compatible with the existing count8b instance. Positional port order is clr, clk, l, s_s, c, d.

Parameters:
- WIDTH, 8, counter and load-data width in bits. All behaviour is stated for 8; must scale to any WIDTH >= 2.
- RST_VAL, 0, value forced onto c by clear.

Ports:
- clk  input  1  rising-edge clock
- clr  input  1  asynchronous active-low clear; c = RST_VAL while low
- l  input  1  synchronous parallel load, active-high
- s_s  input  1  start/stop; 1 = count, 0 = hold
- c  output  WIDTH  current count, registered
- d  input  WIDTH  parallel load data
- tc  output  1  terminal count; present only with COUNT8B_TC_EN

Behaviour:
- clr low: c = RST_VAL immediately, independent of clk. clr has priority over everything else.
- After clr rises, the first active clk edge applies the normal rules. No extra recovery cycle.
- Rising clk edge with clr high:
  - Priority 1, l=1: c <= d. Applies regardless of s_s.
  - Priority 2, l=0 and s_s=1: c <= c+1, modulo 2^WIDTH. 8'hFF wraps to 8'h00 with no sticky flag.
  - Priority 3, l=0 and s_s=0: c holds.
- Latency: a load or increment is visible on c one edge after the inputs are sampled. c is driven directly from the register with no combinational path from the inputs.
- l and s_s held high together: each edge reloads d, so c stays at d. The count does not advance until l falls.
- Reset mid-operation: clr low during counting or loading clears c at once. The pending load or increment is discarded.
- All inputs are sampled only on clk edges (except clr). Glitches between edges have no effect.
- Unknown/X inputs are not handled specially.

Optional Feature:
- Macro: COUNT8B_TC_EN.
- Defined:
  - Adds output tc.
  - tc = 1 combinationally when c == all-ones and s_s == 1 and l == 0, i.e. the next edge wraps.
  - tc = 0 during clr low.
  - Supports cascading counters.
- Undefined: tc port and logic are absent. Remaining behaviour is identical.

Decomposition:
- Shared package count_pkg holds:
  - localparam CNT_W = 8
  - localparam CNT_RST = '0
  - typedef logic [CNT_W-1:0] cnt_t
- Keep the block flat: one register process plus next-state logic. No sub-module is warranted.
- The tc compare stays inline under the macro.

Test Plan:
- Power-on clear: clr=0, toggle clk 5 cycles -> c=8'h00 throughout. Release clr with s_s=0 -> c stays 8'h00.
- Count: clr=1, l=0, s_s=1 for 10 edges from 8'h00 -> c=8'h0A. Drop s_s to 0 for 5 edges -> c holds 8'h0A.
- Load priority: d=8'hF0, l=1, s_s=1 for 3 edges -> c=8'hF0 each edge. l=0 -> next edges give c=8'hF1, 8'hF2.
- Wrap: load 8'hFE, count 3 edges -> 8'hFF, 8'h00, 8'h01. With COUNT8B_TC_EN, tc=1 only while c=8'hFF and s_s=1.
- Async clear mid-count: counting at 8'h37, drop clr between edges -> c=8'h00 before the next edge. Raise clr -> counting resumes 8'h01 on the first edge.
- Load while stopped: s_s=0, d=8'h5A, l=1 for one edge -> c=8'h5A, then holds with l=0 and s_s=0.

Source files
------------

// File: rtl/count_pkg.sv
// Shared definitions for the count8b family of delay/elapsed-cycle counters.
package count_pkg;

  localparam int CNT_W = 8;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_RST = '0;

endpackage

// File: rtl/delay_counter_8b.sv
// Loadable up-counter with start/stop enable and asynchronous active-low clear.
// Optional terminal-count output tc is enabled by defining COUNT8B_TC_EN.
module delay_counter_8b
  import count_pkg::*;
#(
  parameter int               WIDTH   = CNT_W,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(CNT_RST)
) (
  input  logic             clr,
  input  logic             clk,
  input  logic             l,
  input  logic             s_s,
  output logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d
`ifdef COUNT8B_TC_EN
  ,
  output logic             tc
`endif
);

  logic [WIDTH-1:0] cnt_p0;
  logic [WIDTH-1:0] cnt_nxt;

  // Load beats count beats hold; the increment wraps modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] next_count(
    input logic [WIDTH-1:0] cur,
    input logic             ld,
    input logic             run,
    input logic [WIDTH-1:0] din
  );
    logic [WIDTH-1:0] res;
    res = cur;
    if (ld) begin
      res = din;
    end else if (run) begin
      res = cur + {{(WIDTH-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

  always_comb begin
    cnt_nxt = next_count(cnt_p0, l, s_s, d);
  end

  // Stage p0: the count register, the only state in the block
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_p0 <= RST_VAL;
    end else begin
      cnt_p0 <= cnt_nxt;
    end
  end

  assign c = cnt_p0;

`ifdef COUNT8B_TC_EN
  // Gated by clr so a RST_VAL of all-ones cannot raise tc while cleared.
  assign tc = clr & ~l & s_s & (&cnt_p0);
`endif

endmodule

// File: tb/tb_delay_counter_8b.sv
// Table-driven bench for delay_counter_8b with a queue scoreboard; build with
// COUNT8B_TC_EN defined to also exercise the terminal-count output.
module tb_delay_counter_8b;

  logic       clk;
  logic       clr;
  logic       l;
  logic       s_s;
  logic [7:0] c;
  logic [7:0] d;
`ifdef COUNT8B_TC_EN
  logic       tc;
`endif

  int total;
  int bad;

  delay_counter_8b #(.WIDTH(8), .RST_VAL(8'h00)) dut (
    .clr (clr),
    .clk (clk),
    .l   (l),
    .s_s (s_s),
    .c   (c),
    .d   (d)
`ifdef COUNT8B_TC_EN
    ,
    .tc  (tc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       l;
    logic       s_s;
    logic [7:0] d;
    logic [7:0] exp_c;
    logic       exp_tc;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];
  logic       tc_q[$];

  task automatic add(input logic cl, input logic ld, input logic run,
                     input logic [7:0] din, input logic [7:0] ec, input logic et);
    vec_t v;
    v.clr = cl; v.l = ld; v.s_s = run; v.d = din; v.exp_c = ec; v.exp_tc = et;
    vecs.push_back(v);
  endtask

  task automatic check_c(input string name, input logic [7:0] req);
    total++;
    if (c !== req) begin
      bad++;
      $display("FAIL %s: c=%h required=%h at t=%0t", name, c, req, $time);
    end
  endtask

  task automatic check_tc(input string name, input logic req);
`ifdef COUNT8B_TC_EN
    total++;
    if (tc !== req) begin
      bad++;
      $display("FAIL %s: tc=%b required=%b at t=%0t", name, tc, req, $time);
    end
`else
    if (req) begin end
    if (name.len() < 0) begin end
`endif
  endtask

  // Drive one vector just after a falling edge, push expectations, compare after the rising edge.
  task automatic apply(input vec_t v, input string name);
    logic [7:0] ec;
    logic       et;
    @(negedge clk);
    clr = v.clr; l = v.l; s_s = v.s_s; d = v.d;
    exp_q.push_back(v.exp_c);
    tc_q.push_back(v.exp_tc);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      ec = exp_q.pop_front();
      et = tc_q.pop_front();
      check_c(name, ec);
      check_tc({name, "_tc"}, et);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clr = 1'b1; l = 1'b0; s_s = 1'b0; d = 8'h00;
    #1 clr = 1'b0;
    #1 check_c("async_clr_at_start", 8'h00);

    // Power-on clear held, then release with s_s low
    for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 1'b1, 8'hAA, 8'h00, 1'b0);
    for (int i = 0; i < 2; i++) add(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    // Count 10 edges, then hold 5
    for (int i = 1; i <= 10; i++) add(1'b1, 1'b0, 1'b1, 8'h00, 8'(i), 1'b0);
    for (int i = 0; i < 5; i++) add(1'b1, 1'b0, 1'b0, 8'h33, 8'h0A, 1'b0);
    // Load priority over count
    for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 1'b1, 8'hF0, 8'hF0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 8'hF0, 8'hF1, 1'b0);
    add(1'b1, 1'b0, 1'b1, 8'hF0, 8'hF2, 1'b0);
    // Wrap through all-ones
    add(1'b1, 1'b1, 1'b0, 8'hFE, 8'hFE, 1'b0);
    add(1'b1, 1'b0, 1'b1, 8'hFE, 8'hFF, 1'b1);
    add(1'b1, 1'b0, 1'b1, 8'hFE, 8'h00, 1'b0);
    add(1'b1, 1'b0, 1'b1, 8'hFE, 8'h01, 1'b0);
    // Load while stopped, then hold
    add(1'b1, 1'b1, 1'b0, 8'h5A, 8'h5A, 1'b0);
    add(1'b1, 1'b0, 1'b0, 8'h00, 8'h5A, 1'b0);
    add(1'b1, 1'b0, 1'b0, 8'hFF, 8'h5A, 1'b0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // tc follows s_s and l combinationally while c is all-ones
    apply('{1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0}, "tc_load_ff");
    s_s = 1'b1; #1;
    check_tc("tc_ss_rise", 1'b1);
    l = 1'b1; #1;
    check_tc("tc_l_block", 1'b0);
    l = 1'b0; s_s = 1'b0; #1;
    check_tc("tc_ss_fall", 1'b0);
    check_c("hold_ff", 8'hFF);

    // Async clear mid-count discards the pending increment
    apply('{1'b1, 1'b1, 1'b0, 8'h36, 8'h36, 1'b0}, "mid_load");
    apply('{1'b1, 1'b0, 1'b1, 8'h00, 8'h37, 1'b0}, "mid_count");
    #2 clr = 1'b0;
    #1 check_c("mid_clr_async", 8'h00);
    check_tc("mid_clr_tc", 1'b0);
    @(posedge clk); #1;
    check_c("mid_clr_held", 8'h00);
    apply('{1'b1, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0}, "resume_first_edge");
    apply('{1'b1, 1'b0, 1'b1, 8'h00, 8'h02, 1'b0}, "resume_second_edge");

    // Clear while loading also wins
    @(negedge clk);
    l = 1'b1; d = 8'hC3; clr = 1'b0;
    @(posedge clk); #1;
    check_c("clr_over_load", 8'h00);

    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_drain: left=%0d required=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
